bls12_381_interrupt_tx: RTL

- Transmit end of the BLS12-381 interrupt-reply protocol. Software receives and parses this message on the stream interface after a SEND_INTERRUPT instruction.
- On request from the instruction sequencer, the block builds the reply header, then reads N consecutive data-RAM slots.
- Each slot is serialised as 48 little-endian bytes onto the 8-byte AXI-stream toward the host.
- It sits between the sequencer, the data URAM read port and the top-level tx stream.

---
 rtl/bls12_381_interrupt_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bls12_381_interrupt_tx.sv
// BLS12-381 interrupt-reply transmitter.
// Builds a two-beat header (length/command, index/data type) and then streams
// N data-RAM slots. Each slot is zero-extended to 384 bits and sent as six
// 64-bit beats, least-significant word first.
module bls12_381_interrupt_tx #(
    parameter int          DAT_BITS  = 381,
    parameter int          ADDR_BITS = 12,
    parameter int          RD_LAT    = 2,
    parameter int          MAX_SLOTS = 8,
    parameter logic [31:0] CMD_RPL   = 32'h0000_0005
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_val,
    output logic                 o_req_rdy,
    input  logic [15:0]          i_req_index,
    input  logic [7:0]           i_req_data_type,
    input  logic [ADDR_BITS-1:0] i_req_addr,
    input  logic [3:0]           i_req_num,
    output logic                 o_ram_rd_en,
    output logic [ADDR_BITS-1:0] o_ram_rd_addr,
    input  logic [DAT_BITS-1:0]  i_ram_rd_dat,
    output logic [63:0]          o_tx_dat,
    output logic                 o_tx_val,
    input  logic                 i_tx_rdy,
    output logic                 o_tx_sop,
    output logic                 o_tx_eop,
    output logic [2:0]           o_tx_mod,
    output logic                 o_busy
);

    localparam int SH_BITS = 384;
    localparam int WAIT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_READ,
        S_WAIT,
        S_DATA
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            index_q, index_d;
    logic [7:0]             type_q, type_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [3:0]             num_q, num_d;
    logic [3:0]             slot_q, slot_d;
    logic [2:0]             beat_q, beat_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [SH_BITS-1:0]     shreg_q, shreg_d;

    logic [3:0]             req_num_sat;
    logic [31:0]            msg_len;
    logic                   last_slot;

    // Requests above the slot limit are clamped rather than rejected.
    assign req_num_sat = (i_req_num > 4'(MAX_SLOTS)) ? 4'(MAX_SLOTS) : i_req_num;
    assign msg_len     = 32'd16 + 32'd48 * 32'(num_q);
    assign last_slot   = (slot_q == (num_q - 4'd1));
    assign o_tx_mod    = 3'd0;
    assign o_busy      = (state_q != S_IDLE);

    // Next-state, datapath updates and all stream/RAM outputs.
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        type_d        = type_q;
        addr_d        = addr_q;
        num_d         = num_q;
        slot_d        = slot_q;
        beat_d        = beat_q;
        wait_d        = wait_q;
        shreg_d       = shreg_q;
        o_req_rdy     = 1'b0;
        o_ram_rd_en   = 1'b0;
        o_ram_rd_addr = '0;
        o_tx_dat      = 64'd0;
        o_tx_val      = 1'b0;
        o_tx_sop      = 1'b0;
        o_tx_eop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_req_rdy = 1'b1;
                if (i_req_val) begin
                    index_d = i_req_index;
                    type_d  = i_req_data_type;
                    addr_d  = i_req_addr;
                    num_d   = req_num_sat;
                    slot_d  = 4'd0;
                    state_d = S_HDR0;
                end
            end
            S_HDR0: begin
                o_tx_val = 1'b1;
                o_tx_sop = 1'b1;
                o_tx_dat = {CMD_RPL, msg_len};
                if (i_tx_rdy) begin
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                o_tx_val = 1'b1;
                o_tx_dat = {40'd0, type_q, index_q};
                o_tx_eop = (num_q == 4'd0);
                if (i_tx_rdy) begin
                    state_d = (num_q == 4'd0) ? S_IDLE : S_READ;
                end
            end
            S_READ: begin
                // Address arithmetic wraps naturally at the RAM depth.
                o_ram_rd_en   = 1'b1;
                o_ram_rd_addr = addr_q + ADDR_BITS'(slot_q);
                wait_d        = '0;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                    shreg_d = {{(SH_BITS - DAT_BITS){1'b0}}, i_ram_rd_dat};
                    beat_d  = 3'd0;
                    state_d = S_DATA;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DATA: begin
                o_tx_val = 1'b1;
                o_tx_dat = shreg_q[63:0];
                o_tx_eop = (beat_q == 3'd5) && last_slot;
                if (i_tx_rdy) begin
                    shreg_d = shreg_q >> 64;
                    if (beat_q == 3'd5) begin
                        if (last_slot) begin
                            state_d = S_IDLE;
                        end else begin
                            slot_d  = slot_q + 4'd1;
                            state_d = S_READ;
                        end
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset truncates any message in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            index_q <= '0;
            type_q  <= '0;
            addr_q  <= '0;
            num_q   <= '0;
            slot_q  <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
            slot_q  <= slot_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            shreg_q <= shreg_d;
        end
    end

endmodule
